// File: rtl/mmcm_drp_reconfig.sv
// MMCM runtime reconfiguration: holds the MMCM in reset, read-modify-writes a ROM-supplied
// table of DRP registers, releases reset and waits for lock, with DRP and lock timeouts.
module mmcm_drp_reconfig #(
    parameter int CFG_W        = 2,
    parameter int NUM_WRITES   = 8,
    parameter int IDX_W        = 3,
    parameter int DRP_TIMEOUT  = 1024,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                   clk125,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CFG_W-1:0]       cfg_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [CFG_W+IDX_W-1:0] rom_addr,
    input  logic [38:0]            rom_data,
    output logic                   drp_den,
    output logic                   drp_dwe,
    output logic [6:0]             drp_daddr,
    output logic [15:0]            drp_di,
    input  logic [15:0]            drp_do,
    input  logic                   drp_drdy,
    output logic                   mmcm_rst,
    input  logic                   mmcm_locked
);

    localparam int TMR_MAX = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    // The timer starts at 0 in the first wait cycle, so the limit sits two below the budget.
    localparam logic [TMR_W-1:0] DRP_LIM  = TMR_W'(DRP_TIMEOUT - 2);
    localparam logic [TMR_W-1:0] LOCK_LIM = TMR_W'(LOCK_TIMEOUT - 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WRITES - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RST       = 4'd1,
        S_FETCH     = 4'd2,
        S_RD        = 4'd3,
        S_RD_WAIT   = 4'd4,
        S_WR        = 4'd5,
        S_WR_WAIT   = 4'd6,
        S_RELEASE   = 4'd7,
        S_LOCK_WAIT = 4'd8
    } state_t;

    state_t             r_state;
    logic [CFG_W-1:0]   r_cfg;
    logic [IDX_W-1:0]   r_idx;
    logic [15:0]        r_mask;
    logic [15:0]        r_data;
    logic               r_fetch_ph;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_lock_meta;
    logic               r_lock_sync;
    logic [IDX_W-1:0]   w_idx_nxt;

    assign w_idx_nxt = r_idx + IDX_W'(1);

    function automatic logic [15:0] f_merge(input logic [15:0] rd_val,
                                            input logic [15:0] keep,
                                            input logic [15:0] new_bits);
        return (rd_val & keep) | (new_bits & ~keep);
    endfunction

    // Two-flop synchroniser for the asynchronous MMCM lock
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= mmcm_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    // Reconfiguration sequencer with registered outputs
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cfg      <= '0;
            r_idx      <= '0;
            r_mask     <= 16'h0000;
            r_data     <= 16'h0000;
            r_fetch_ph <= 1'b0;
            r_tmr      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            rom_addr   <= '0;
            drp_den    <= 1'b0;
            drp_dwe    <= 1'b0;
            drp_daddr  <= 7'h00;
            drp_di     <= 16'h0000;
            mmcm_rst   <= 1'b0;
        end else begin
            done    <= 1'b0;
            error   <= 1'b0;
            drp_den <= 1'b0;
            drp_dwe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cfg    <= cfg_sel;
                        r_idx    <= '0;
                        busy     <= 1'b1;
                        mmcm_rst <= 1'b1;
                        r_state  <= S_RST;
                    end
                end
                S_RST: begin
                    rom_addr   <= {r_cfg, r_idx};
                    r_fetch_ph <= 1'b0;
                    r_state    <= S_FETCH;
                end
                S_FETCH: begin
                    // First cycle only lets the synchronous ROM respond to the new address.
                    if (!r_fetch_ph) begin
                        r_fetch_ph <= 1'b1;
                    end else begin
                        drp_daddr <= rom_data[38:32];
                        r_mask    <= rom_data[31:16];
                        r_data    <= rom_data[15:0];
                        drp_den   <= 1'b1;
                        r_state   <= S_RD;
                    end
                end
                S_RD: begin
                    r_tmr   <= '0;
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (drp_drdy) begin
                        drp_di  <= f_merge(drp_do, r_mask, r_data);
                        drp_den <= 1'b1;
                        drp_dwe <= 1'b1;
                        r_state <= S_WR;
                    end else if (r_tmr == DRP_LIM) begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        mmcm_rst <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_WR: begin
                    r_tmr   <= '0;
                    r_state <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (drp_drdy) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_RELEASE;
                        end else begin
                            r_idx      <= w_idx_nxt;
                            rom_addr   <= {r_cfg, w_idx_nxt};
                            r_fetch_ph <= 1'b0;
                            r_state    <= S_FETCH;
                        end
                    end else if (r_tmr == DRP_LIM) begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        mmcm_rst <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                S_RELEASE: begin
                    mmcm_rst <= 1'b0;
                    r_tmr    <= '0;
                    r_state  <= S_LOCK_WAIT;
                end
                S_LOCK_WAIT: begin
                    if (r_lock_sync) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_tmr == LOCK_LIM) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                default: begin
                    busy     <= 1'b0;
                    mmcm_rst <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Bench for mmcm_drp_reconfig: synchronous ROM, DRP register-file model with per-access
// latency, lock model, and a reference model of the table read-modify-write sequence.
module tb_mmcm_drp_reconfig;

    localparam int CFG_W   = 2;
    localparam int IDX_W   = 3;
    localparam int NW      = 8;
    localparam int DRP_TO  = 40;
    localparam int LOCK_TO = 200;

    logic        clk125 = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic        busy, done, error;
    logic [4:0]  rom_addr;
    logic [38:0] rom_data;
    logic        drp_den, drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'h0000;
    logic        drp_drdy = 1'b0;
    logic        mmcm_rst;
    logic        mmcm_locked;
    logic        lock_en = 1'b1;

    int n_vec = 0;
    int n_mis = 0;

    always #4 clk125 = ~clk125;

    mmcm_drp_reconfig #(
        .CFG_W(CFG_W), .NUM_WRITES(NW), .IDX_W(IDX_W),
        .DRP_TIMEOUT(DRP_TO), .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .clk125(clk125), .rst_n(rst_n), .start(start), .cfg_sel(cfg_sel),
        .busy(busy), .done(done), .error(error), .rom_addr(rom_addr),
        .rom_data(rom_data), .drp_den(drp_den), .drp_dwe(drp_dwe),
        .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do),
        .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
    );

    // External environment: ROM, MMCM lock, DRP register file
    logic [38:0] rom [0:31];
    logic [15:0] mem_init [0:127];
    logic [15:0] mem [0:127];
    int lat_q [0:15];
    int drop_rd = 0;
    int acc_n = 0, rd_n = 0, pend = 0, cur_lat = 1;

    always @(posedge clk125) rom_data <= rom[rom_addr];
    assign mmcm_locked = lock_en & ~mmcm_rst;

    always @(posedge clk125) begin
        drp_drdy <= 1'b0;
        if (start && !busy) begin
            for (int i = 0; i < 128; i++) mem[i] = mem_init[i];
            acc_n = 0;
            rd_n  = 0;
            pend  = 0;
        end
        if (drp_den) begin
            cur_lat = (acc_n < 16) ? lat_q[acc_n] : 1;
            acc_n++;
            if (drp_dwe) begin
                mem[drp_daddr] = drp_di;
            end else begin
                drp_do <= mem[drp_daddr];
                rd_n++;
            end
            if (!drp_dwe && rd_n == drop_rd) pend = 0;
            else if (cur_lat <= 1) drp_drdy <= 1'b1;
            else pend = cur_lat - 1;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) drp_drdy <= 1'b1;
        end
    end

    // Monitor: cycle-relative log of one operation, counted from the accepted start
    int rel = 0;
    int log_addr[$], log_we[$], log_di[$], log_ra[$], log_cyc[$];
    int done_n = 0, err_n = 0, done_rel = -1, err_rel = -1, both_n = 0;
    bit busy_h [0:1023];
    bit rst_h  [0:1023];

    always @(negedge clk125) begin
        if (rst_n) begin
            if (start && !busy) begin
                rel = 0;
                log_addr.delete(); log_we.delete(); log_di.delete();
                log_ra.delete(); log_cyc.delete();
                done_n = 0; err_n = 0; done_rel = -1; err_rel = -1;
            end else begin
                rel++;
            end
            if (drp_den) begin
                log_addr.push_back(int'(drp_daddr));
                log_we.push_back(int'(drp_dwe));
                log_di.push_back(int'(drp_di));
                log_ra.push_back(int'(rom_addr));
                log_cyc.push_back(rel);
            end
            if (done)  begin done_n++; done_rel = rel; end
            if (error) begin err_n++;  err_rel  = rel; end
            if (done && error) both_n++;
            if (rel < 1024) begin
                busy_h[rel] = busy;
                rst_h[rel]  = mmcm_rst;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_done"},     done, 0);
        chk({tag, "_error"},    error, 0);
        chk({tag, "_den"},      drp_den, 0);
        chk({tag, "_dwe"},      drp_dwe, 0);
        chk({tag, "_mmcm_rst"}, mmcm_rst, 0);
        chk({tag, "_daddr"},    drp_daddr, 0);
        chk({tag, "_di"},       drp_di, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
    endtask

    task automatic pulse_start(input logic [1:0] c);
        @(posedge clk125); #1;
        cfg_sel = c;
        start   = 1'b1;
        @(posedge clk125); #1;
        start   = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk125); #1;
            if (done || error) seen = 1'b1;
        end
        chk("run_terminated", seen, 1);
        repeat (2) @(posedge clk125);
        #1;
    endtask

    task automatic set_lat(input bit rnd);
        for (int i = 0; i < 16; i++) lat_q[i] = rnd ? int'($urandom_range(1, 4)) : 1;
    endtask

    // Reference: walk the table over a copy of the register file; timing from wait counts
    task automatic check_run(input logic [1:0] c);
        logic [15:0] m [0:127];
        logic [38:0] e;
        logic [6:0]  a;
        logic [15:0] w;
        logic [4:0]  ra;
        int extra;
        extra = 0;
        for (int i = 0; i < 128; i++) m[i] = mem_init[i];
        chk("access_count", log_addr.size(), 2 * NW);
        if (log_addr.size() == 2 * NW) begin
            for (int i = 0; i < NW; i++) begin
                ra = {c, 3'(i)};
                e  = rom[ra];
                a  = e[38:32];
                w  = (m[a] & e[31:16]) | (e[15:0] & ~e[31:16]);
                m[a] = w;
                chk("rom_addr",  log_ra[2*i],     ra);
                chk("rd_addr",   log_addr[2*i],   a);
                chk("rd_we",     log_we[2*i],     0);
                chk("wr_addr",   log_addr[2*i+1], a);
                chk("wr_we",     log_we[2*i+1],   1);
                chk("wr_di",     log_di[2*i+1],   w);
                extra += lat_q[2*i] + lat_q[2*i+1] - 2;
            end
        end
        chk("done_count",  done_n, 1);
        chk("error_count", err_n, 0);
        chk("done_cycle",  done_rel, 6 * NW + 6 + extra);
        chk("busy_cycle1", busy_h[1], 1);
        chk("rst_cycle1",  rst_h[1], 1);
        if (done_rel > 4 && done_rel < 1024) begin
            chk("busy_at_done",   busy_h[done_rel], 0);
            chk("busy_before",    busy_h[done_rel-1], 1);
            chk("rst_at_release", rst_h[done_rel-4], 1);
            chk("rst_after_rel",  rst_h[done_rel-3], 0);
        end
    endtask

    typedef struct {
        logic [15:0] do_v;
        logic [15:0] mask;
        logic [15:0] data;
        logic [15:0] exp_di;
    } tv_t;
    tv_t tv [0:7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [1:0] c;
        tv[0] = '{16'hABCD, 16'hFFFF, 16'h1234, 16'hABCD};
        tv[1] = '{16'hABCD, 16'h0000, 16'h1234, 16'h1234};
        tv[2] = '{16'h5555, 16'h00FF, 16'h1200, 16'h1255};
        tv[3] = '{16'hABCD, 16'h1000, 16'h0145, 16'h0145};
        tv[4] = '{16'hFFFF, 16'hF0F0, 16'h0000, 16'hF0F0};
        tv[5] = '{16'h0000, 16'hF0F0, 16'hFFFF, 16'h0F0F};
        tv[6] = '{16'h1234, 16'hFF00, 16'hABCD, 16'h12CD};
        tv[7] = '{16'h8001, 16'h8001, 16'h7FFE, 16'hFFFF};

        for (int i = 0; i < 32; i++) rom[i] = {$urandom, $urandom};
        for (int i = 0; i < 128; i++) mem_init[i] = 16'hABCD;
        set_lat(1'b0);

        // Reset state
        #20;
        chk_reset_outputs("in_reset");
        @(posedge clk125); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk125);
        #1;
        chk_reset_outputs("after_reset");

        // Nominal: cfg 1, entry 0 from the plan, registers read back as 0xABCD
        for (int i = 0; i < NW; i++)
            rom[8+i] = {7'(8 + i), 16'($urandom), 16'($urandom)};
        rom[8] = {7'h08, 16'h1000, 16'h0145};
        pulse_start(2'd1);
        wait_end(200);
        check_run(2'd1);
        chk("nominal_first_di", log_di.size() > 1 ? log_di[1] : -1, 16'h0145);
        chk("nominal_done_54",  done_rel, 54);
        chk("idle_busy", busy, 0);

        // Table-driven merge vectors, one per table entry of cfg 2
        for (int i = 0; i < NW; i++) begin
            rom[16+i] = {7'(7'h40 + i), tv[i].mask, tv[i].data};
            mem_init[7'h40 + i] = tv[i].do_v;
        end
        pulse_start(2'd2);
        wait_end(200);
        check_run(2'd2);
        for (int i = 0; i < NW; i++)
            chk("table_di", log_di.size() == 2*NW ? log_di[2*i+1] : -1, tv[i].exp_di);

        // Random tables, register contents and DRP latencies
        for (int k = 0; k < 6; k++) begin
            c = 2'($urandom_range(0, 3));
            for (int i = 0; i < NW; i++) rom[{c, 3'(i)}] = {$urandom, $urandom};
            for (int i = 0; i < 128; i++) mem_init[i] = 16'($urandom);
            set_lat(1'b1);
            pulse_start(c);
            wait_end(300);
            check_run(c);
        end

        // start with a different cfg while in RD_WAIT is ignored
        set_lat(1'b0);
        pulse_start(2'd0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk125); #1;
            if (log_addr.size() >= 3) seen = 1'b1;
        end
        chk("reach_second_read", seen, 1);
        pulse_start(2'd3);
        wait_end(200);
        check_run(2'd0);
        repeat (60) @(posedge clk125);
        #1;
        chk("ignored_start_done_once", done_n, 1);
        chk("ignored_start_no_den",    log_addr.size(), 2 * NW);

        // Third read never acknowledged
        drop_rd = 3;
        pulse_start(2'd1);
        wait_end(300);
        repeat (20) @(posedge clk125);
        #1;
        chk("drp_to_den_count", log_addr.size(), 5);
        chk("drp_to_error_cyc", err_rel, (log_cyc.size() > 4 ? log_cyc[4] : 0) + DRP_TO);
        chk("drp_to_error_n",   err_n, 1);
        chk("drp_to_no_done",   done_n, 0);
        chk("drp_to_rst_low",   (err_rel >= 0 && err_rel < 1024) ? rst_h[err_rel] : 1'b1, 0);
        chk("drp_to_busy_low",  (err_rel >= 0 && err_rel < 1024) ? busy_h[err_rel] : 1'b1, 0);
        chk("drp_to_rst_now",   mmcm_rst, 0);
        drop_rd = 0;

        // Lock never comes; then a normal run
        lock_en = 1'b0;
        pulse_start(2'd1);
        wait_end(6 * NW + LOCK_TO + 50);
        chk("lock_to_error_cyc", err_rel, 2 + 6 * NW + LOCK_TO);
        chk("lock_to_error_n",   err_n, 1);
        chk("lock_to_no_done",   done_n, 0);
        chk("lock_to_rst_low",   mmcm_rst, 0);
        lock_en = 1'b1;
        pulse_start(2'd1);
        wait_end(200);
        check_run(2'd1);

        // Asynchronous reset during WR_WAIT, then restart from index 0
        pulse_start(2'd1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk125); #1;
            if (log_addr.size() >= 6) seen = 1'b1;
        end
        chk("reach_third_write", seen, 1);
        @(posedge clk125); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(posedge clk125); #1;
        rst_n = 1'b1;
        pulse_start(2'd1);
        wait_end(200);
        check_run(2'd1);

        chk("done_error_overlap", both_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
